board_ram_arbiter: RTL
======================

Name: board_ram_arbiter

Overview:
- Shares the single-port 4-word sudoku board RAM between two requesters: the board-edit write port (input controller) and the gameChecker read/scan port.
- Arbitrates round-robin by default, or with fixed write priority; drives the RAM address, write-enable and write-data pins.
- Returns read data with fixed latency.
- Tracks a boardDirty flag so the checker only rescans after an edit.

Parameters:
ADDR_W, 2, RAM address width (board rows, DEPTH = 2**ADDR_W)
DATA_W, 24, RAM word width (packed row of cells)
WR_PRIORITY, 0, 0 = round-robin between ports; 1 = write always wins a conflict

Ports:
CLK  in  1  system clock, rising edge
RSTn  in  1  asynchronous active-low reset
wrReq  in  1  write request; held with wrAddr/wrDat until wrGnt
wrAddr  in  ADDR_W  write row address
wrDat  in  DATA_W  write data
wrGnt  out  1  write granted this cycle (combinational)
rdReq  in  1  read request; held with rdAddr until rdGnt
rdAddr  in  ADDR_W  read row address
rdGnt  out  1  read granted this cycle (combinational)
rdDat  out  DATA_W  registered read data
rdValid  out  1  rdDat valid, one-cycle pulse
boardDirty  out  1  board edited since last clean full scan
RamAddr  out  ADDR_W  RAM address
RamWe  out  1  RAM write enable
RamWrDat  out  DATA_W  RAM write data
RamDat  in  DATA_W  RAM read data, valid 1 cycle after address (synchronous read)

Behaviour:
- Reset (RSTn low, async):
  - lastGnt = READ, so the first conflict goes to write under round-robin.
  - rdValid = 0, rdDat = 0, read pipeline flag cleared.
  - boardDirty = 1, scanClean = 0.
  - RamWe = 0, RamAddr = 0, RamWrDat = 0.
- Grant (combinational from req and lastGnt):
  - Only one request: it is granted.
  - Both requested, WR_PRIORITY = 1: write granted.
  - Both requested, WR_PRIORITY = 0: grant the port not in lastGnt.
  - lastGnt updates on every grant edge; never both grants in one cycle.
- Grant cycle:
  - Write: RamAddr = wrAddr, RamWe = 1, RamWrDat = wrDat.
  - Read: RamAddr = rdAddr, RamWe = 0.
- Idle cycle: RamWe = 0; RamAddr and RamWrDat hold their last values.
- Read latency: rdGnt in cycle N -> RamDat valid in N+1 -> registered into rdDat, rdValid = 1 in N+2 for exactly one cycle.
  - Back-to-back read grants produce back-to-back rdValid pulses.
  - rdDat holds its value when rdValid = 0.
- Read after write to the same address in the next cycle returns the new data (RAM write-then-read ordering); no bypass needed.
- Dirty tracking:
  - Write grant: boardDirty <= 1 and scanClean <= 0.
  - Read grant at address 0: scanClean <= 1.
  - Read grant at address DEPTH-1 with scanClean = 1: boardDirty <= 0 and scanClean <= 0.
  - Reads need not be sequential; an intervening write voids the scan.
- Held requests: a request held across cycles without a grant must not change address or data. The arbiter does not latch inputs; a change before grant is a protocol violation and is not checked.
- Reset mid-read: any in-flight read is dropped and no rdValid is issued after reset release. The requester re-requests.

Test Plan:
- Reset: RSTn = 0 at t = 0, release -> boardDirty = 1, rdValid = 0, RamWe = 0, lastGnt = READ.
- Single write: wrReq, wrAddr = 2, wrDat = 24'h001324 -> wrGnt same cycle, RamWe = 1, RamAddr = 2, RamWrDat = 24'h001324; boardDirty stays 1.
- Read latency: rdReq, rdAddr = 2 after the write -> rdGnt cycle N, rdValid in N+2 with rdDat = 24'h001324, rdValid low in N+3.
- Round-robin conflict (WR_PRIORITY = 0): both requests held 4 cycles -> grants alternate W, R, W, R starting with W after reset. With WR_PRIORITY = 1 -> W every cycle, rdGnt = 0.
- Dirty clear: read rows 0, 1, 2, 3 with no writes -> boardDirty falls the cycle after the row-3 grant. Repeat with a write to row 1 between the row-0 and row-3 reads -> boardDirty stays 1.
- Reset mid-read: rdGnt at cycle N, RSTn low in N+1 -> no rdValid after release, boardDirty = 1.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port sudoku board RAM between the edit write port and the checker read port
// Ports:
//   CLK, RSTn                      clock, async active-low reset
//   wrReq/wrAddr/wrDat -> wrGnt    board-edit write port, combinational grant
//   rdReq/rdAddr -> rdGnt          checker read port, combinational grant
//   rdDat, rdValid                 registered read data, valid two cycles after rdGnt
//   boardDirty                     board edited since the last clean row-0..last-row scan
//   RamAddr, RamWe, RamWrDat       RAM pins, driven in the grant cycle, address/data held when idle
//   RamDat                         synchronous RAM read data, valid one cycle after address
module board_ram_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 24,
  parameter bit WR_PRIORITY = 1'b0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrDat,
  output logic              wrGnt,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdGnt,
  output logic [DATA_W-1:0] rdDat,
  output logic              rdValid,
  output logic              boardDirty,
  output logic [ADDR_W-1:0] RamAddr,
  output logic              RamWe,
  output logic [DATA_W-1:0] RamWrDat,
  input  logic [DATA_W-1:0] RamDat
);
  localparam logic [ADDR_W-1:0] LAST_ROW = '1;
  logic lastGnt;
  logic rdPend;
  logic scanClean;
  logic [ADDR_W-1:0] addrHold;
  logic [DATA_W-1:0] datHold;
  // lastGnt = 1 means the read port was granted last; grants are suppressed while in reset
  always_comb begin
    wrGnt = RSTn && wrReq && (!rdReq || WR_PRIORITY || lastGnt);
    rdGnt = RSTn && rdReq && !wrGnt;
    RamWe = wrGnt;
    RamAddr = wrGnt ? wrAddr : rdGnt ? rdAddr : addrHold;
    RamWrDat = wrGnt ? wrDat : datHold;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lastGnt <= 1'b1;
      rdPend <= 1'b0;
      rdValid <= 1'b0;
      rdDat <= '0;
      boardDirty <= 1'b1;
      scanClean <= 1'b0;
      addrHold <= '0;
      datHold <= '0;
    end else begin
      rdPend <= rdGnt;
      rdValid <= rdPend;
      if (rdPend) rdDat <= RamDat;
      if (wrGnt || rdGnt) begin
        lastGnt <= rdGnt;
        addrHold <= RamAddr;
      end
      // a scan is clean only if row 0 .. last row are read with no write in between
      if (wrGnt) begin
        datHold <= wrDat;
        boardDirty <= 1'b1;
        scanClean <= 1'b0;
      end else if (rdGnt && rdAddr == LAST_ROW && scanClean) begin
        boardDirty <= 1'b0;
        scanClean <= 1'b0;
      end else if (rdGnt && rdAddr == '0) begin
        scanClean <= 1'b1;
      end
    end
  end
endmodule
